traffic_ctrl: RTL and testbench
===============================

TRAFFIC_CTRL -- requirements
Module: traffic_ctrl

Interface
REQ-001 Parameter GREEN_S, default 20, green phase length in ticks.
REQ-002 Parameter YELLOW_S, default 3, yellow phase length in ticks.
REQ-003 Parameter ALLRED_S, default 2, all-red phase length in ticks.
REQ-004 Parameter WALK_S, default 10, all-red length in ticks when a walk is served.
REQ-005 Parameter SHORT_S, default 5, remaining green after a pedestrian request shortens it; legal range 1 <= SHORT_S < GREEN_S, all parameters 1..99.
REQ-006 Ports: clk  in  1  system clock; single clock domain for the whole block.
REQ-007 rst  in  1  reset; asynchronous, active-high.
REQ-008 tick  in  1  1 Hz enable from the clock divider; each clk cycle with tick=1 counts as one tick.
REQ-009 ped_req  in  1  asynchronous pedestrian button, level.
REQ-010 night  in  1  night-mode select, level.
REQ-011 ns_light  out  3  north-south lamps {R,Y,G}, one-hot or 000.
REQ-012 ew_light  out  3  east-west lamps {R,Y,G}.
REQ-013 walk  out  1  pedestrian walk lamp.
REQ-014 count  out  7  seconds remaining in the current phase, unsigned binary.

Function
REQ-015 FSM states: NS_GREEN, NS_YELLOW, RED_TO_EW, EW_GREEN, EW_YELLOW, RED_TO_NS, NIGHT.
REQ-016 Normal order: NS_GREEN -> NS_YELLOW -> RED_TO_EW -> EW_GREEN -> EW_YELLOW -> RED_TO_NS -> NS_GREEN.
REQ-017 All state and count changes occur only on clk edges with tick=1; with tick=0, outputs hold.
REQ-018 On phase entry, count loads that phase's duration; each tick with count>1 decrements count; a tick with count==1 moves to the next phase and loads its duration in the same edge.
REQ-019 Phase lamps: NS_GREEN ns=001 ew=100; NS_YELLOW ns=010 ew=100; EW_GREEN ns=100 ew=001; EW_YELLOW ns=100 ew=010; RED_TO_EW/RED_TO_NS ns=100 ew=100.
REQ-020 ped_req is synchronized by two flops; a synchronized rising edge sets ped_pending on the following clk edge, independent of tick.
REQ-021 Green shortening: a tick in NS_GREEN or EW_GREEN with ped_pending=1 and count>SHORT_S loads count=SHORT_S instead of decrementing.
REQ-022 Walk service: entering RED_TO_EW or RED_TO_NS with ped_pending=1 loads WALK_S instead of ALLRED_S, clears ped_pending, and asserts walk for that whole phase; otherwise walk=0.
REQ-023 A rising edge of ped_req during a walk phase sets ped_pending again for the next all-red phase.
REQ-024 A tick with night=1 in any normal state enters NIGHT: count=0, walk=0, ped_pending cleared, red lamps off, both yellow lamps equal to a flash bit.
REQ-025 In NIGHT the flash bit starts at 1 on entry and toggles on every tick.
REQ-026 A tick with night=0 in NIGHT enters RED_TO_NS with count=ALLRED_S.
REQ-027 Precedence on one tick edge: night entry > phase transition > green shortening > decrement.
REQ-028 A ped_req edge coinciding with a tick is latched; it takes effect from the next tick.

Reset
REQ-029 rst=1 immediately, without clk, forces state=RED_TO_NS, count=ALLRED_S, ns_light=100, ew_light=100, walk=0, ped_pending=0, flash=0, and clears the synchronizer flops.
REQ-030 Assertion of rst mid-phase, including in NIGHT or a walk phase, aborts that phase with no partial completion; operation resumes from RED_TO_NS after release.

Verification
REQ-031 Release reset, 2 ticks -> count 2,1; then NS_GREEN with ns=001, count=20.
REQ-032 Free-run from NS_GREEN entry -> phases last 20/3/2/20/3/2 ticks; NS_GREEN re-entered after exactly 50 ticks.
REQ-033 Pulse ped_req in NS_GREEN at count=15, then a tick -> count=5; 5 ticks later NS_YELLOW; RED_TO_EW has count=10 and walk=1 for 10 ticks; ped_pending then 0.
REQ-034 Pulse ped_req in EW_GREEN at count=4 -> no shortening; next RED_TO_NS lasts 10 ticks with walk=1.
REQ-035 Set night=1 in EW_YELLOW -> next tick: NIGHT, count=0, yellows=1, reds=0; yellows toggle each tick; clear night -> next tick: RED_TO_NS, count=2.
REQ-036 Assert rst between ticks in EW_GREEN at count=7 -> outputs become ns=100, ew=100, count=2 without a clk edge.

Source files
------------

// File: rtl/traffic_ctrl.sv
// Two-road traffic light controller with pedestrian walk phase
// and a flashing-yellow night mode, paced by a 1 Hz tick enable.
module traffic_ctrl #(
  parameter int GREEN_S  = 20,
  parameter int YELLOW_S = 3,
  parameter int ALLRED_S = 2,
  parameter int WALK_S   = 10,
  parameter int SHORT_S  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_req,
  input  logic       night,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [6:0] count
);

  typedef enum logic [2:0] {
    NS_GREEN, NS_YELLOW, RED_TO_EW,
    EW_GREEN, EW_YELLOW, RED_TO_NS, NIGHT
  } state_t;

  localparam logic [6:0] G_D = 7'(GREEN_S);
  localparam logic [6:0] Y_D = 7'(YELLOW_S);
  localparam logic [6:0] R_D = 7'(ALLRED_S);
  localparam logic [6:0] W_D = 7'(WALK_S);
  localparam logic [6:0] S_D = 7'(SHORT_S);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  state_t     state, state_n, nxt;
  logic [6:0] cnt, cnt_n, dur;
  logic       walk_r, walk_n;
  logic       pend, pend_n, pend_clr;
  logic       flash, flash_n;
  logic       s1, s2, s3;
  logic       rise;

  assign rise = s2 & ~s3;

  // State, counter, walk, pending, flash and button synchronizer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RED_TO_NS;
      cnt    <= R_D;
      walk_r <= 1'b0;
      pend   <= 1'b0;
      flash  <= 1'b0;
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      walk_r <= walk_n;
      pend   <= pend_n;
      flash  <= flash_n;
      s1     <= ped_req;
      s2     <= s1;
      s3     <= s2;
    end
  end

  // Successor phase and its duration in the normal cycle
  always_comb begin
    nxt = RED_TO_NS;
    dur = R_D;
    unique case (state)
      NS_GREEN:  begin nxt = NS_YELLOW; dur = Y_D; end
      NS_YELLOW: begin nxt = RED_TO_EW; dur = R_D; end
      RED_TO_EW: begin nxt = EW_GREEN;  dur = G_D; end
      EW_GREEN:  begin nxt = EW_YELLOW; dur = Y_D; end
      EW_YELLOW: begin nxt = RED_TO_NS; dur = R_D; end
      RED_TO_NS: begin nxt = NS_GREEN;  dur = G_D; end
      default:   begin nxt = RED_TO_NS; dur = R_D; end
    endcase
  end

  // Tick-driven next state: night > transition > shorten > decrement
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    walk_n   = walk_r;
    flash_n  = flash;
    pend_clr = 1'b0;
    if (tick) begin
      if (state != NIGHT && night) begin
        state_n  = NIGHT;
        cnt_n    = 7'd0;
        walk_n   = 1'b0;
        flash_n  = 1'b1;
        pend_clr = 1'b1;
      end else if (state == NIGHT) begin
        if (!night) begin
          state_n = RED_TO_NS;
          cnt_n   = R_D;
          flash_n = 1'b0;
        end else begin
          flash_n = ~flash;
        end
      end else if (cnt <= 7'd1) begin
        state_n = nxt;
        walk_n  = 1'b0;
        cnt_n   = dur;
        if ((nxt == RED_TO_EW || nxt == RED_TO_NS) && pend) begin
          cnt_n    = W_D;
          walk_n   = 1'b1;
          pend_clr = 1'b1;
        end
      end else if ((state == NS_GREEN || state == EW_GREEN)
                   && pend && cnt > S_D) begin
        cnt_n = S_D;
      end else begin
        cnt_n = cnt - 7'd1;
      end
    end
    // A fresh press survives a same-edge clear so it serves the next phase
    pend_n = (pend & ~pend_clr) | (rise & (state_n != NIGHT));
  end

  // Lamp decode from the current phase
  always_comb begin
    ns_light = RED;
    ew_light = RED;
    unique case (state)
      NS_GREEN:  begin ns_light = GRN; ew_light = RED; end
      NS_YELLOW: begin ns_light = YEL; ew_light = RED; end
      EW_GREEN:  begin ns_light = RED; ew_light = GRN; end
      EW_YELLOW: begin ns_light = RED; ew_light = YEL; end
      NIGHT: begin
        ns_light = {1'b0, flash, 1'b0};
        ew_light = {1'b0, flash, 1'b0};
      end
      default:   begin ns_light = RED; ew_light = RED; end
    endcase
  end

  assign walk  = walk_r;
  assign count = cnt;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Scoreboard bench for traffic_ctrl: stimulus queues expected
// lamp/walk/count values, a monitor compares them at negedge.
module tb_traffic_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       ped_req = 1'b0;
  logic       night = 1'b0;
  logic [2:0] ns_light, ew_light;
  logic       walk;
  logic [6:0] count;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] O = 3'b000;

  typedef struct {
    string      name;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       w;
    logic [6:0] c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  traffic_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick),
    .ped_req(ped_req), .night(night),
    .ns_light(ns_light), .ew_light(ew_light),
    .walk(walk), .count(count)
  );

  always #5 clk = ~clk;

  // Monitor: compare every queued expectation at the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (ns_light !== e.ns || ew_light !== e.ew ||
            walk !== e.w || count !== e.c) begin
          errors++;
          $display("FAIL %s: got ns=%b ew=%b walk=%b count=%0d, want ns=%b ew=%b walk=%b count=%0d",
                   e.name, ns_light, ew_light, walk, count,
                   e.ns, e.ew, e.w, e.c);
        end
      end
    end
  end

  task automatic expect_st(input string n, input logic [2:0] ns,
                           input logic [2:0] ew, input logic w,
                           input int c);
    exp_t e;
    e.name = n; e.ns = ns; e.ew = ew; e.w = w; e.c = 7'(c);
    q.push_back(e);
  endtask

  task automatic do_tick();
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
  endtask

  // One tick per expected count value, from hi down to lo
  task automatic run(input string n, input logic [2:0] ns,
                     input logic [2:0] ew, input logic w,
                     input int hi, input int lo);
    for (int c = hi; c >= lo; c--) begin
      do_tick();
      expect_st(n, ns, ew, w, c);
    end
  endtask

  task automatic press();
    @(negedge clk);
    ped_req = 1'b1;
    repeat (3) @(negedge clk);
    ped_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 expect_st("reset", R, R, 1'b0, 2);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    run("startup_red", R, R, 1'b0, 1, 1);
    run("startup_nsg", G, R, 1'b0, 20, 20);

    run("free_nsg", G, R, 1'b0, 19, 1);
    run("free_nsy", Y, R, 1'b0, 3, 1);
    run("free_r2ew", R, R, 1'b0, 2, 1);
    run("free_ewg", R, G, 1'b0, 20, 1);
    run("free_ewy", R, Y, 1'b0, 3, 1);
    run("free_r2ns", R, R, 1'b0, 2, 1);
    run("free_nsg_again", G, R, 1'b0, 20, 20);

    run("ped_nsg_pre", G, R, 1'b0, 19, 15);
    press();
    expect_st("hold_no_tick", G, R, 1'b0, 15);
    run("ped_shorten", G, R, 1'b0, 5, 5);
    run("ped_nsg_rest", G, R, 1'b0, 4, 1);
    run("ped_nsy", Y, R, 1'b0, 3, 1);
    run("walk_r2ew", R, R, 1'b1, 10, 1);
    run("ewg_no_pend", R, G, 1'b0, 20, 4);
    press();
    run("ewg_no_shorten", R, G, 1'b0, 3, 1);
    run("ewy", R, Y, 1'b0, 3, 1);
    run("walk_r2ns_a", R, R, 1'b1, 10, 6);
    press();
    run("walk_r2ns_b", R, R, 1'b1, 5, 1);
    run("nsg_after_rewalk", G, R, 1'b0, 20, 20);
    run("nsg_reshort", G, R, 1'b0, 5, 1);
    run("nsy2", Y, R, 1'b0, 3, 1);
    run("walk_r2ew2", R, R, 1'b1, 10, 1);
    run("ewg2", R, G, 1'b0, 20, 1);
    run("ewy_enter", R, Y, 1'b0, 3, 3);

    night = 1'b1;
    do_tick(); expect_st("night_on", Y, Y, 1'b0, 0);
    do_tick(); expect_st("night_flash0", O, O, 1'b0, 0);
    do_tick(); expect_st("night_flash1", Y, Y, 1'b0, 0);
    night = 1'b0;
    run("night_exit", R, R, 1'b0, 2, 1);
    run("nsg3", G, R, 1'b0, 20, 1);
    run("nsy3", Y, R, 1'b0, 3, 1);
    run("r2ew3", R, R, 1'b0, 2, 1);
    run("ewg3", R, G, 1'b0, 20, 7);

    @(posedge clk);
    #2 rst = 1'b1;
    expect_st("async_reset", R, R, 1'b0, 2);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    run("post_reset_red", R, R, 1'b0, 1, 1);
    run("post_reset_nsg", G, R, 1'b0, 20, 20);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
